// File: rtl/uart_loader_pkg.sv
// Shared types and constants for the UART program loader.
package uart_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        DATA,
        CKSUM,
        ACK_WAIT,
        ACK_SEND,
        DONE,
        ERR
    } state_t;

    localparam logic [7:0] ACK_OK         = 8'hAA;
    localparam logic [7:0] ACK_NG         = 8'hEE;
    localparam int         BYTES_PER_WORD = 4;

endpackage

// File: rtl/byte_packer.sv
// Little-endian shift-in assembler: four accepted bytes form one 32-bit word,
// flagged combinationally on the cycle the fourth byte arrives.
import uart_loader_pkg::*;

module byte_packer (
    input  logic        clk,
    input  logic        rstn,
    input  logic        clear,
    input  logic        in_valid,
    input  logic [7:0]  in_byte,
    output logic [31:0] word,
    output logic        word_valid
);
    localparam logic [1:0] LAST = 2'(BYTES_PER_WORD - 1);

    logic [1:0]  cnt;
    logic [23:0] sh;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= 2'd0;
            sh  <= 24'd0;
        end else if (clear) begin
            cnt <= 2'd0;
            sh  <= 24'd0;
        end else if (in_valid) begin
            cnt <= cnt + 2'd1;
            sh  <= {in_byte, sh[23:8]};
        end
    end

    // Oldest byte ends up in bits 7:0 once three bytes have been shifted in.
    assign word       = {in_byte, sh};
    assign word_valid = in_valid && (cnt == LAST);

endmodule

// File: rtl/uart_rx_loader.sv
// Serial program loader: length word, N data words written to memory, status reply.
// Optional trailing checksum byte when UART_RX_LOADER_CKSUM_EN is defined.
import uart_loader_pkg::*;

module uart_rx_loader #(
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_ready,
    input  logic              rx_ferr,
    output logic [7:0]        tx_data,
    output logic              tx_start,
    input  logic              tx_busy,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err
);
    localparam logic [32:0] MAX_WORDS = 33'd1 << ADDR_W;
`ifdef UART_RX_LOADER_CKSUM_EN
    localparam state_t POST_DATA = CKSUM;
`else
    localparam state_t POST_DATA = ACK_WAIT;
`endif

    state_t            state, state_n;
    logic [7:0]        reply, reply_n;
    logic [ADDR_W-1:0] wcnt, last_idx;
    logic              seen_busy, err_q;
    logic              pk_clear, pk_valid, set_err, wr_fire, send, len_load;
    logic [31:0]       pk_word;
    logic              pk_word_valid;
`ifdef UART_RX_LOADER_CKSUM_EN
    logic [7:0]        cksum;
`endif

    byte_packer u_packer (
        .clk        (clk),
        .rstn       (rstn),
        .clear      (pk_clear),
        .in_valid   (pk_valid),
        .in_byte    (rx_data),
        .word       (pk_word),
        .word_valid (pk_word_valid)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n  = state;
        reply_n  = reply;
        pk_clear = 1'b0;
        pk_valid = 1'b0;
        set_err  = 1'b0;
        wr_fire  = 1'b0;
        send     = 1'b0;
        len_load = 1'b0;
        case (state)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_n  = LEN;
                    pk_clear = 1'b1;
                end
            end
            LEN: begin
                if (rx_ready && rx_ferr) begin
                    state_n = ACK_WAIT;
                    reply_n = ACK_NG;
                    set_err = 1'b1;
                end else if (rx_ready) begin
                    pk_valid = 1'b1;
                    if (pk_word_valid) begin
                        if (pk_word == 32'd0) begin
                            state_n = POST_DATA;
                            reply_n = ACK_OK;
                        end else if ({1'b0, pk_word} > MAX_WORDS) begin
                            state_n = ACK_WAIT;
                            reply_n = ACK_NG;
                            set_err = 1'b1;
                        end else begin
                            state_n  = DATA;
                            len_load = 1'b1;
                        end
                    end
                end
            end
            DATA: begin
                if (rx_ready && rx_ferr) begin
                    state_n = ACK_WAIT;
                    reply_n = ACK_NG;
                    set_err = 1'b1;
                end else if (rx_ready) begin
                    pk_valid = 1'b1;
                    if (pk_word_valid) begin
                        wr_fire = 1'b1;
                        if (wcnt == last_idx) begin
                            state_n = POST_DATA;
                            reply_n = ACK_OK;
                        end
                    end
                end
            end
`ifdef UART_RX_LOADER_CKSUM_EN
            CKSUM: begin
                if (rx_ready) begin
                    state_n = ACK_WAIT;
                    if (!rx_ferr && rx_data == cksum) begin
                        reply_n = ACK_OK;
                    end else begin
                        reply_n = ACK_NG;
                        set_err = 1'b1;
                    end
                end
            end
`endif
            ACK_WAIT: begin
                if (!tx_busy) begin
                    send    = 1'b1;
                    state_n = ACK_SEND;
                end
            end
            ACK_SEND: begin
                // Finished only after the transmitter has visibly taken the byte.
                if (seen_busy && !tx_busy) state_n = (reply == ACK_OK) ? DONE : ERR;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            reply     <= 8'd0;
            tx_data   <= 8'd0;
            tx_start  <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 32'd0;
            wcnt      <= '0;
            last_idx  <= '0;
            seen_busy <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            reply    <= reply_n;
            tx_start <= send;
            mem_we   <= wr_fire;
            if (send) tx_data <= reply;
            if (wr_fire) begin
                mem_addr  <= wcnt;
                mem_wdata <= pk_word;
                wcnt      <= wcnt + 1'b1;
            end
            if (len_load) last_idx <= ADDR_W'(pk_word - 32'd1);
            if (send)                               seen_busy <= 1'b0;
            else if (state == ACK_SEND && tx_busy)  seen_busy <= 1'b1;
            if (pk_clear) begin
                wcnt     <= '0;
                last_idx <= '0;
                err_q    <= 1'b0;
            end else if (set_err) begin
                err_q <= 1'b1;
            end
        end
    end

`ifdef UART_RX_LOADER_CKSUM_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                        cksum <= 8'd0;
        else if (pk_clear)                cksum <= 8'd0;
        else if (pk_valid && state == DATA) cksum <= cksum + rx_data;
    end
`endif

    assign busy = (state == LEN) || (state == DATA) || (state == CKSUM) ||
                  (state == ACK_WAIT) || (state == ACK_SEND);
    assign done = (state == DONE);
    assign err  = err_q;

endmodule

// File: tb/tb_uart_rx_loader.sv
// Bench for uart_rx_loader (ADDR_W=2): vector table, directed corner sequences,
// and random loads scored against a byte-stream reference model.
module tb_uart_rx_loader;
    localparam int         AW   = 2;
    localparam int         MAXW = 4;
    localparam logic [7:0] OK   = 8'hAA;
    localparam logic [7:0] NG   = 8'hEE;

    logic          clk = 1'b0;
    logic          rstn, start, rx_ready, rx_ferr, tx_start, mem_we, busy, done, err;
    logic [7:0]    rx_data, tx_data;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          tx_busy, hold_busy;
    int            tx_left = 0;

    int checks = 0, errors = 0;
    logic [7:0]  stim[$];
    int          fe_idx;
    logic [63:0] wr_q[$], exp_q[$];
    int          tx_cnt;
    logic [7:0]  tx_last;
    logic        prev_txs = 1'b0;

    always #5 clk = ~clk;

    uart_rx_loader #(.ADDR_W(AW)) dut (
        .clk(clk), .rstn(rstn), .start(start), .rx_data(rx_data), .rx_ready(rx_ready),
        .rx_ferr(rx_ferr), .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .done(done), .err(err)
    );

    // Simple transmitter: busy for 6 cycles starting the cycle after a request.
    always @(posedge clk) begin
        if (tx_start)         tx_left <= 6;
        else if (tx_left > 0) tx_left <= tx_left - 1;
    end
    assign tx_busy = (tx_left != 0) || hold_busy;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rstn) begin
            if (mem_we) wr_q.push_back({32'(mem_addr), mem_wdata});
            if (tx_start) begin
                chk("tx_start_width", {63'd0, prev_txs}, 64'd0);
                tx_cnt++;
                tx_last = tx_data;
            end
        end
        prev_txs = tx_start;
    end

    task automatic send_byte(input logic [7:0] b, input bit fe);
        @(negedge clk);
        rx_data = b; rx_ready = 1'b1; rx_ferr = fe;
        @(negedge clk);
        rx_ready = 1'b0; rx_ferr = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
    endtask

    task automatic send_stim();
        for (int i = 0; i < stim.size(); i++) send_byte(stim[i], i == fe_idx);
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_end();
        int k = 0;
        while (!(!busy && (done || err)) && k < 3000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 3000) chk("timeout", 64'd1, 64'd0);
        repeat (3) @(negedge clk);
    endtask

    task automatic run_load();
        wr_q.delete(); tx_cnt = 0;
        pulse_start();
        send_stim();
        wait_end();
    endtask

    // Length word, then 4n data bytes, then (checksum build) the byte sum; stream cut at the ferr byte.
    task automatic build_stim(input int n, input int fe, input bit bad_ck, input bit rnd);
        logic [7:0] b, s;
        logic [31:0] nw;
        stim.delete();
        nw = n;
        for (int i = 0; i < 4; i++) stim.push_back(nw[8*i +: 8]);
        if (n <= MAXW) begin
            s = 8'd0;
            for (int k = 0; k < 4 * n; k++) begin
                b = rnd ? 8'($urandom) : 8'(k * 37 + 5);
                stim.push_back(b);
                s = s + b;
            end
`ifdef UART_RX_LOADER_CKSUM_EN
            stim.push_back(s + 8'(bad_ck));
`endif
        end
        fe_idx = (fe < stim.size()) ? fe : -1;
        if (fe_idx >= 0) while (stim.size() > fe_idx + 1) void'(stim.pop_back());
    endtask

    // Reference: interpret the byte stream directly from the protocol rules.
    task automatic model(output logic [7:0] rep);
        logic [31:0] n;
        logic [7:0]  s;
        int lim;
        exp_q.delete();
        rep = NG;
        lim = (fe_idx >= 0) ? fe_idx : stim.size();
        if (lim < 4) return;
        n = {stim[3], stim[2], stim[1], stim[0]};
        if (n > 32'(MAXW)) return;
        s = 8'd0;
        for (int k = 0; k < int'(n); k++) begin
            if (lim < 8 + 4 * k) return;
            exp_q.push_back({32'(k), stim[7+4*k], stim[6+4*k], stim[5+4*k], stim[4+4*k]});
            for (int j = 4 + 4 * k; j < 8 + 4 * k; j++) s = s + stim[j];
        end
`ifdef UART_RX_LOADER_CKSUM_EN
        if (lim < 5 + 4 * int'(n)) return;
        rep = (stim[4 + 4 * int'(n)] == s) ? OK : NG;
`else
        rep = OK;
`endif
    endtask

    task automatic cmp_writes();
        chk("wr_count", 64'(wr_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < wr_q.size() && i < exp_q.size(); i++) chk("wr_addr_data", wr_q[i], exp_q[i]);
    endtask

    typedef struct {
        int n; int fe; bit bad_ck;
        logic [7:0] rep; bit dn; int nwr;
    } vec_t;
    vec_t tab[10];

    initial begin
        logic [7:0] rep;
        rstn = 1'b0; start = 1'b0; rx_data = 8'd0; rx_ready = 1'b0; rx_ferr = 1'b0; hold_busy = 1'b0;
        tab[0] = '{1, -1, 0, OK, 1, 1};
        tab[1] = '{4, -1, 0, OK, 1, 4};
        tab[2] = '{5, -1, 0, NG, 0, 0};
        tab[3] = '{65536, -1, 0, NG, 0, 0};
        tab[4] = '{3, 1, 0, NG, 0, 0};
        tab[5] = '{3, 9, 0, NG, 0, 1};
        tab[6] = '{2, 11, 0, NG, 0, 1};
        tab[7] = '{0, -1, 0, OK, 1, 0};
`ifdef UART_RX_LOADER_CKSUM_EN
        tab[8] = '{2, -1, 1, NG, 0, 2};
        tab[9] = '{2, 12, 0, NG, 0, 2};
`else
        tab[8] = '{2, -1, 1, OK, 1, 2};
        tab[9] = '{2, 12, 0, OK, 1, 2};
`endif
        repeat (3) @(negedge clk);
        chk("reset_outputs", {tx_data, tx_start, mem_we, 32'(mem_addr), mem_wdata, busy, done, err}, 64'd0);
        rstn = 1'b1;

        // Directed: two-word load, with a start pulse mid-transfer that must be ignored.
        stim = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
`ifdef UART_RX_LOADER_CKSUM_EN
        stim.push_back(8'h4C);
`endif
        fe_idx = -1; wr_q.delete(); tx_cnt = 0;
        pulse_start();
        for (int i = 0; i < stim.size(); i++) begin
            send_byte(stim[i], 1'b0);
            if (i == 7) pulse_start();
        end
        wait_end();
        exp_q = '{{32'd0, 32'h12345678}, {32'd1, 32'hDEADBEEF}};
        cmp_writes();
        chk("d1_tx_cnt", 64'(tx_cnt), 64'd1);
        chk("d1_reply", 64'(tx_last), 64'(OK));
        chk("d1_done_err", {62'd0, done, err}, 64'd2);

        // Table vectors.
        foreach (tab[t]) begin
            build_stim(tab[t].n, tab[t].fe, tab[t].bad_ck, 1'b0);
            run_load();
            model(rep);
            chk("tab_reply", 64'(tx_last), 64'(tab[t].rep));
            chk("tab_tx_cnt", 64'(tx_cnt), 64'd1);
            chk("tab_done_err", {62'd0, done, err}, {62'd0, tab[t].dn, !tab[t].dn});
            chk("tab_nwr", 64'(wr_q.size()), 64'(tab[t].nwr));
            cmp_writes();
        end

        // Framing error, then start clears err and re-arms.
        build_stim(1, 5, 0, 1'b0);
        run_load();
        chk("fe_err", {63'd0, err}, 64'd1);
        chk("fe_reply", 64'(tx_last), 64'(NG));
        chk("fe_nwr", 64'(wr_q.size()), 64'd0);
        pulse_start();
        chk("fe_restart", {62'd0, err, busy}, 64'd1);
        build_stim(0, -1, 0, 1'b0);
        send_stim();
        wait_end();
        chk("fe_then_done", {63'd0, done}, 64'd1);

        // Transmitter held busy: no request until it frees up, then exactly one.
        hold_busy = 1'b1;
        build_stim(0, -1, 0, 1'b0);
        run_load_hold: begin
            wr_q.delete(); tx_cnt = 0;
            pulse_start();
            send_stim();
            repeat (100) @(negedge clk);
            chk("hold_no_start", 64'(tx_cnt), 64'd0);
            hold_busy = 1'b0;
            wait_end();
        end
        chk("hold_tx_cnt", 64'(tx_cnt), 64'd1);
        chk("hold_reply", 64'(tx_last), 64'(OK));

        // start and rx_ready together from DONE: the byte must not be counted.
        wr_q.delete(); tx_cnt = 0;
        @(negedge clk); start = 1'b1; rx_ready = 1'b1; rx_data = 8'h01;
        @(negedge clk); start = 1'b0; rx_ready = 1'b0;
        build_stim(0, -1, 0, 1'b0);
        send_stim();
        wait_end();
        chk("start_wins_done", {63'd0, done}, 64'd1);
        chk("start_wins_nwr", 64'(wr_q.size()), 64'd0);

`ifdef UART_RX_LOADER_CKSUM_EN
        stim = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h01, 8'h01, 8'h02, 8'h02, 8'h02, 8'h02, 8'h0C};
        fe_idx = -1;
        run_load();
        exp_q = '{{32'd0, 32'h01010101}, {32'd1, 32'h02020202}};
        cmp_writes();
        chk("ck_ok", {tx_last, 6'd0, done, err}, {OK, 8'h02});
        stim[12] = 8'h0D;
        run_load();
        chk("ck_bad", {tx_last, 6'd0, done, err}, {NG, 8'h01});
`endif

        // Random loads against the model.
        for (int r = 0; r < 25; r++) begin
            int n, fe;
            n  = $urandom_range(0, MAXW + 1);
            fe = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 4 + 4 * n) : -1;
            build_stim(n, fe, $urandom_range(0, 4) == 0, 1'b1);
            run_load();
            model(rep);
            chk("rnd_reply", 64'(tx_last), 64'(rep));
            chk("rnd_tx_cnt", 64'(tx_cnt), 64'd1);
            chk("rnd_done_err", {62'd0, done, err}, {62'd0, rep == OK, rep != OK});
            cmp_writes();
        end

        // Asynchronous reset in the middle of the data phase.
        build_stim(2, -1, 0, 1'b0);
        wr_q.delete(); tx_cnt = 0;
        pulse_start();
        for (int i = 0; i < 9; i++) send_byte(stim[i], 1'b0);
        @(negedge clk);
        chk("mid_busy", {63'd0, busy}, 64'd1);
        chk("mid_wdata", 64'(mem_wdata), {32'd0, stim[7], stim[6], stim[5], stim[4]});
        #3 rstn = 1'b0;
        #1 chk("async_reset", {tx_data, tx_start, mem_we, 32'(mem_addr), mem_wdata, busy, done, err}, 64'd0);
        @(negedge clk); rstn = 1'b1;
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
